// File: rtl/semaforo_pkg.sv
// Shared state encodings and default phase durations for the timed traffic light.
package semaforo_pkg;

    typedef enum logic [1:0] {
        S_VERDE    = 2'b00,
        S_AMARELO  = 2'b01,
        S_VERMELHO = 2'b10,
        S_PISCA    = 2'b11
    } estado_t;

    localparam int T_VERDE_MIN_DEF = 8;
    localparam int T_AMARELO_DEF   = 3;
    localparam int T_VERMELHO_DEF  = 6;
    localparam int T_PISCA_DEF     = 4;
    localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/semaforo_temporizado_temporizador.sv
// Phase timer: clear on state change, optional saturate or wrap at the limit,
// terminal-count flag compares the current count against the limit.
module temporizador #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             clr_i,
    input  logic             sat_i,
    input  logic             wrap_i,
    input  logic [CNT_W-1:0] lim_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o  = (cnt_q == lim_i);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i) begin
            cnt_d = '0;
        end else if (tc_o && wrap_i) begin
            cnt_d = '0;
        end else if (tc_o && sat_i) begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/semaforo_temporizado.sv
// Timed traffic light with pedestrian request and night blinking-amber mode.
// Lamps are registered from the next state so they always agree with ESTADO.
module semaforo_temporizado
    import semaforo_pkg::*;
#(
    parameter int T_VERDE_MIN = T_VERDE_MIN_DEF,
    parameter int T_AMARELO   = T_AMARELO_DEF,
    parameter int T_VERMELHO  = T_VERMELHO_DEF,
    parameter int T_PISCA     = T_PISCA_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       res,
    input  logic       CAR,
    input  logic       PED,
    input  logic       NOITE,
    output logic       VERDE,
    output logic       AMARELO,
    output logic       VERMELHO,
    output logic       PED_VERDE,
    output logic [1:0] ESTADO
);

    localparam logic [CNT_W-1:0] LIM_V = CNT_W'(T_VERDE_MIN - 1);
    localparam logic [CNT_W-1:0] LIM_A = CNT_W'(T_AMARELO - 1);
    localparam logic [CNT_W-1:0] LIM_R = CNT_W'(T_VERMELHO - 1);
    localparam logic [CNT_W-1:0] LIM_P = CNT_W'(T_PISCA - 1);

    estado_t          state_q, state_d;
    logic             ped_pend_q, ped_pend_d;
    logic             blink_q, blink_d;
    logic             verde_q, amarelo_q, vermelho_q, ped_verde_q;
    logic [CNT_W-1:0] lim;
    logic [CNT_W-1:0] cnt;
    logic             tc;

    always_comb begin
        lim = LIM_V;
        case (state_q)
            S_VERDE:    lim = LIM_V;
            S_AMARELO:  lim = LIM_A;
            S_VERMELHO: lim = LIM_R;
            S_PISCA:    lim = LIM_P;
            default:    lim = LIM_V;
        endcase
    end

    temporizador #(
        .CNT_W (CNT_W)
    ) u_temporizador (
        .clk    (clk),
        .res    (res),
        .clr_i  (state_d != state_q),
        .sat_i  (state_q == S_VERDE),
        .wrap_i (state_q == S_PISCA),
        .lim_i  (lim),
        .cnt_o  (cnt),
        .tc_o   (tc)
    );

    always_comb begin
        state_d    = state_q;
        blink_d    = 1'b0;
        ped_pend_d = ped_pend_q;
        case (state_q)
            S_VERDE: begin
                if (NOITE) begin
                    state_d = S_PISCA;
                end else if ((cnt >= LIM_V) && (CAR || ped_pend_q)) begin
                    state_d = S_AMARELO;
                end
            end
            S_AMARELO: begin
                // Night mode never cuts amber short; it only redirects the exit.
                if (tc) begin
                    state_d = NOITE ? S_PISCA : S_VERMELHO;
                end
            end
            S_VERMELHO: begin
                if (NOITE) begin
                    state_d = S_PISCA;
                end else if (tc) begin
                    state_d = S_VERDE;
                end
            end
            S_PISCA: begin
                if (!NOITE) begin
                    state_d = S_VERMELHO;
                end
            end
            default: state_d = S_VERDE;
        endcase

        if (state_d == S_PISCA) begin
            if (state_q != S_PISCA) begin
                blink_d = 1'b1;
            end else begin
                blink_d = tc ? ~blink_q : blink_q;
            end
        end

        // Entering red serves the request, and that takes priority over a new one.
        if ((state_d == S_VERMELHO) && (state_q != S_VERMELHO)) begin
            ped_pend_d = 1'b0;
        end else if (PED && (state_q != S_VERMELHO)) begin
            ped_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= S_VERDE;
            ped_pend_q  <= 1'b0;
            blink_q     <= 1'b0;
            verde_q     <= 1'b1;
            amarelo_q   <= 1'b0;
            vermelho_q  <= 1'b0;
            ped_verde_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ped_pend_q  <= ped_pend_d;
            blink_q     <= blink_d;
            verde_q     <= (state_d == S_VERDE);
            amarelo_q   <= (state_d == S_AMARELO) || ((state_d == S_PISCA) && blink_d);
            vermelho_q  <= (state_d == S_VERMELHO);
            ped_verde_q <= (state_d == S_VERMELHO);
        end
    end

    assign VERDE     = verde_q;
    assign AMARELO   = amarelo_q;
    assign VERMELHO  = vermelho_q;
    assign PED_VERDE = ped_verde_q;
    assign ESTADO    = state_q;

endmodule

// File: tb/tb_semaforo_temporizado.sv
// Directed scenarios with a queue-based scoreboard checking ESTADO and all lamps every cycle.
module tb_semaforo_temporizado;
    import semaforo_pkg::*;

    logic       clk   = 1'b0;
    logic       res   = 1'b1;
    logic       car   = 1'b0;
    logic       ped   = 1'b0;
    logic       noite = 1'b0;
    logic       verde, amarelo, vermelho, ped_verde;
    logic [1:0] estado;

    // Expected vector: {ESTADO, VERDE, AMARELO, VERMELHO, PED_VERDE}
    localparam logic [5:0] EV  = {S_VERDE,    4'b1000};
    localparam logic [5:0] EA  = {S_AMARELO,  4'b0100};
    localparam logic [5:0] ER  = {S_VERMELHO, 4'b0011};
    localparam logic [5:0] EP1 = {S_PISCA,    4'b0100};
    localparam logic [5:0] EP0 = {S_PISCA,    4'b0000};

    logic [5:0] exp_q[$];
    string      tag_q[$];
    string      tag = "reset";
    int         checks   = 0;
    int         failures = 0;
    logic [5:0] mon_exp;
    logic [5:0] mon_got;
    string      mon_tag;

    always #5 clk = ~clk;

    semaforo_temporizado #(
        .T_VERDE_MIN (4),
        .T_AMARELO   (2),
        .T_VERMELHO  (5),
        .T_PISCA     (3),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .res       (res),
        .CAR       (car),
        .PED       (ped),
        .NOITE     (noite),
        .VERDE     (verde),
        .AMARELO   (amarelo),
        .VERMELHO  (vermelho),
        .PED_VERDE (ped_verde),
        .ESTADO    (estado)
    );

    // Drive inputs for n edges; e is the output expected after each of those edges.
    task automatic cyc(input int n, input logic r, input logic c, input logic p,
                       input logic nt, input logic [5:0] e);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            res   = r;
            car   = c;
            ped   = p;
            noite = nt;
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                mon_got = {estado, verde, amarelo, vermelho, ped_verde};
                checks++;
                if (mon_got !== mon_exp) begin
                    failures++;
                    $display("FAIL %s t=%0t got=%b expected=%b", mon_tag, $time, mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        tag = "reset";
        cyc(2, 1, 0, 0, 0, EV);

        tag = "car_cycle";
        cyc(3, 0, 1, 0, 0, EV);
        cyc(2, 0, 1, 0, 0, EA);
        cyc(5, 0, 1, 0, 0, ER);
        cyc(4, 0, 1, 0, 0, EV);
        cyc(2, 0, 1, 0, 0, EA);
        cyc(5, 0, 1, 0, 0, ER);
        tag = "reset_in_red";
        cyc(1, 1, 0, 0, 0, EV);

        tag = "ped_pulse";
        cyc(1, 0, 0, 0, 0, EV);
        cyc(1, 0, 0, 1, 0, EV);
        cyc(1, 0, 0, 0, 0, EV);
        cyc(2, 0, 0, 0, 0, EA);
        tag = "ped_clear_wins";
        cyc(1, 0, 0, 1, 0, ER);
        tag = "ped_in_red";
        cyc(4, 0, 0, 1, 0, ER);
        cyc(1, 0, 0, 1, 0, EV);
        tag = "green_saturate";
        cyc(49, 0, 0, 0, 0, EV);

        tag = "night_from_amber";
        cyc(1, 0, 1, 0, 0, EA);
        cyc(1, 0, 0, 0, 1, EA);
        cyc(3, 0, 0, 0, 1, EP1);
        cyc(3, 0, 0, 0, 1, EP0);
        cyc(2, 0, 0, 0, 1, EP1);
        tag = "night_exit_red";
        cyc(1, 0, 0, 0, 0, ER);
        cyc(4, 0, 0, 0, 0, ER);
        cyc(3, 0, 0, 0, 0, EV);
        tag = "night_from_green";
        cyc(3, 0, 0, 0, 1, EP1);
        tag = "reset_in_pisca";
        cyc(1, 1, 0, 0, 1, EV);

        tag = "reset_third_red";
        cyc(3, 0, 1, 0, 0, EV);
        cyc(2, 0, 1, 0, 0, EA);
        cyc(3, 0, 1, 0, 0, ER);
        cyc(1, 1, 0, 0, 0, EV);
        tag = "after_reset";
        cyc(3, 0, 1, 0, 0, EV);
        cyc(2, 0, 1, 0, 0, EA);
        cyc(1, 0, 1, 0, 0, ER);
        tag = "night_from_red";
        cyc(1, 0, 0, 0, 1, EP1);
        cyc(1, 0, 0, 0, 0, ER);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
